// File: rtl/bin_to_bcd_signed_pkg.sv
// Shared definitions for the multiplier datapath: FSM encoding, BCD digit
// count and the per-digit double-dabble correction.
package bin_to_bcd_signed_pkg;

  localparam int DIGITS  = 3;
  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // A digit of 5 or more would overflow past 9 when doubled by the next shift.
  function automatic logic [DIGIT_W-1:0] add_three(input logic [DIGIT_W-1:0] digit);
    return (digit >= 4'd5) ? digit + 4'd3 : digit;
  endfunction

endpackage

// File: rtl/bin_to_bcd_signed_if.sv
// Request/result bundle between the multiplier and the signed BCD converter.
interface bin_to_bcd_signed_if #(
  parameter int WORD_LENGTH = 5
);
  logic                       start;
  logic [2*WORD_LENGTH-1:0]   Data;
  logic                       busy;
  logic                       done;
  logic                       Sign;
  logic [3:0]                 Units;
  logic [3:0]                 Tens;
  logic [3:0]                 Hundreds;

  modport master (
    output start, Data,
    input  busy, done, Sign, Units, Tens, Hundreds
  );

  modport slave (
    input  start, Data,
    output busy, done, Sign, Units, Tens, Hundreds
  );
endinterface

// File: rtl/bin_to_bcd_signed_add_three.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is >= 5.
module bcd_add_three
  import bin_to_bcd_signed_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_in,
  output logic [DIGIT_W-1:0] digit_out
);

  assign digit_out = add_three(digit_in);

endmodule

// File: rtl/bin_to_bcd_signed.sv
// Signed binary-to-BCD converter for the multiplier product, one bit per
// cycle (double dabble) with a fixed 2*WORD_LENGTH+1 cycle latency.
//
//   state | meaning
//   IDLE  | waiting for start; result outputs hold the last conversion
//   SHIFT | one correct-and-shift step per cycle, 2*WORD_LENGTH steps
//   DONE  | publish sign and digits, pulse done, return to IDLE
module bin_to_bcd_signed
  import bin_to_bcd_signed_pkg::*;
#(
  parameter int WORD_LENGTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  bin_to_bcd_signed_if.slave    bus
);

  localparam int MAG_W = 2 * WORD_LENGTH;
  localparam int BCD_W = DIGITS * DIGIT_W;
  localparam int STEPS = 2 * WORD_LENGTH;
  localparam int CNT_W = $clog2(STEPS + 1);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  state_t             state, state_next;

  logic               sign_q;
  logic [MAG_W-1:0]   mag_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   cnt_q;

  logic               sign_out;
  logic [DIGIT_W-1:0] units_out;
  logic [DIGIT_W-1:0] tens_out;
  logic [DIGIT_W-1:0] hundreds_out;
  logic               done_q;

  logic               data_neg;
  logic [MAG_W-1:0]   data_mag;
  logic               busy_c;

  // The most negative input negates to itself, which read unsigned is the
  // correct magnitude 2^(MAG_W-1).
  assign data_neg = bus.Data[MAG_W-1];
  assign data_mag = data_neg ? (~bus.Data) + MAG_W'(1) : bus.Data;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add_three u_add_three (
      .digit_in  (bcd_q[g*DIGIT_W +: DIGIT_W]),
      .digit_out (bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy_c     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy_c = 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy_c     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Working registers: loaded on an accepted start, stepped in SHIFT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sign_q <= 1'b0;
      mag_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            sign_q <= data_neg;
            mag_q  <= data_mag;
            bcd_q  <= '0;
            cnt_q  <= '0;
          end
        end
        SHIFT: begin
          {bcd_q, mag_q} <= {bcd_adj[BCD_W-2:0], mag_q, 1'b0};
          cnt_q          <= cnt_q + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers change only on the DONE edge so the outputs hold
  // between conversions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sign_out     <= 1'b0;
      units_out    <= '0;
      tens_out     <= '0;
      hundreds_out <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == DONE) begin
        sign_out     <= sign_q;
        units_out    <= bcd_q[0*DIGIT_W +: DIGIT_W];
        tens_out     <= bcd_q[1*DIGIT_W +: DIGIT_W];
        hundreds_out <= bcd_q[2*DIGIT_W +: DIGIT_W];
        done_q       <= 1'b1;
      end
    end
  end

  assign bus.busy     = busy_c;
  assign bus.done     = done_q;
  assign bus.Sign     = sign_out;
  assign bus.Units    = units_out;
  assign bus.Tens     = tens_out;
  assign bus.Hundreds = hundreds_out;

endmodule

// File: tb/tb_bin_to_bcd_signed.sv
// Scoreboard bench for bin_to_bcd_signed: the driver queues expected results,
// a monitor pops and compares on every done pulse.
module tb_bin_to_bcd_signed;

  typedef struct packed {
    logic       sign;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] units;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  exp_t sb[$];
  exp_t last_exp;
  logic prev_done;

  bin_to_bcd_signed_if #(.WORD_LENGTH(5)) bus ();

  bin_to_bcd_signed #(.WORD_LENGTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  function automatic exp_t model(input logic [9:0] d);
    exp_t e;
    int   v;
    int   m;
    v = int'($signed(d));
    m = (v < 0) ? -v : v;
    e.sign     = (v < 0);
    e.hundreds = 4'(m / 100);
    e.tens     = 4'((m / 10) % 10);
    e.units    = 4'(m % 10);
    return e;
  endfunction

  function automatic exp_t mk(input logic s, input int h, input int t, input int u);
    exp_t e;
    e.sign = s; e.hundreds = 4'(h); e.tens = 4'(t); e.units = 4'(u);
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation and
  // last exactly one cycle.
  always @(negedge clk) begin
    exp_t got;
    if (bus.done) begin
      got = {bus.Sign, bus.Hundreds, bus.Tens, bus.Units};
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done got=%h expected=no_done", got);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL result got=%h expected=%h", got, e);
        end
      end
      if (prev_done) begin
        failures++;
        $display("FAIL done_width got=2+ cycles expected=1");
      end
    end
    prev_done = bus.done;
  end

  // Runs one conversion; optionally re-pulses start so that it is sampled on
  // edge k+restart_at (k = accepting edge) with rdata.
  task automatic convert(input logic [9:0] d, input exp_t e,
                         input int restart_at, input logic [9:0] rdata);
    int lat;
    int busy_cnt;
    @(negedge clk);
    bus.Data  = d;
    bus.start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    busy_cnt  = bus.busy ? 1 : 0;
    lat       = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == restart_at - 1) begin
        bus.start = 1'b1;
        bus.Data  = rdata;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    bus.start = 1'b0;
    check("latency", lat, 11);
    check("busy_cycles", busy_cnt, 11);
    @(negedge clk);
    check("busy_after", int'(bus.busy), 0);
    check("hold", int'({bus.Sign, bus.Hundreds, bus.Tens, bus.Units}), int'(e));
    last_exp = e;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    prev_done = 1'b0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.Data  = '0;
    #1;
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_outputs", int'({bus.Sign, bus.Hundreds, bus.Tens, bus.Units}), 0);
    #20;
    @(negedge clk);
    reset = 1'b1;

    convert(10'd0,   mk(0, 0, 0, 0), 0, '0);
    convert(10'd511, mk(0, 5, 1, 1), 0, '0);
    convert(10'h200, mk(1, 5, 1, 2), 0, '0);
    convert(10'h3FF, mk(1, 0, 0, 1), 0, '0);
    convert(10'd75,  mk(0, 0, 7, 5), 4, 10'd3);
    // start coincident with the DONE edge is dropped
    convert(10'd123, mk(0, 1, 2, 3), 11, 10'd9);
    repeat (15) @(negedge clk);
    check("no_restart_busy", int'(bus.busy), 0);

    // reset in mid-conversion of -100
    @(negedge clk);
    bus.Data  = 10'h39C;
    bus.start = 1'b1;
    sb.push_back(mk(1, 1, 0, 0));
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    #1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_outputs", int'({bus.Sign, bus.Hundreds, bus.Tens, bus.Units}), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (14) @(negedge clk);
    check("abort_no_busy", int'(bus.busy), 0);
    convert(10'd42, mk(0, 0, 4, 2), 0, '0);

    for (int i = 0; i < 1024; i++) begin
      convert(10'(i), model(10'(i)), 0, '0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
